alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 4-bit combinational ALU between two requesters (e.g. main datapath and a secondary unit), one operation at a time.
- Per-requester valid/ready request and response channels.
- Round-robin arbitration; operands registered before driving the ALU; result and flags registered and held until the winning requester accepts them.

Parameters:
WIDTH, 4, operand/result width
SEL_W, 4, ALU op-select width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  request valid, bit i = requester i
req_a0, req_a1  input  WIDTH  operand A, requester 0/1
req_b0, req_b1  input  WIDTH  operand B, requester 0/1
req_ci  input  2  carry-in, bit i = requester i
req_sel0, req_sel1  input  SEL_W  ALU op select, requester 0/1
req_ready  output  2  request accepted this cycle (one-hot or zero)
rsp_valid  output  2  response valid (one-hot or zero)
rsp_ready  input  2  requester accepts response
rsp_result  output  WIDTH  registered ALU result
rsp_flags  output  4  registered {N,Z,C,V}
alu_a, alu_b  output  WIDTH  to ALU operands
alu_ci  output  1  to ALU carry-in
alu_sel  output  SEL_W  to ALU op select
alu_result  input  WIDTH  from ALU
alu_n, alu_z, alu_c, alu_v  input  1  from ALU flags
busy  output  1  high in EXEC or RESP
grant_id  output  1  requester currently owning the ALU

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; operand regs 0; priority pointer=0 (requester 0 favoured). Deassertion takes effect on the next clk edge.
- IDLE:
  - req_ready is combinational. If exactly one req_valid bit is set, that requester is granted. If both are set, the pointer's requester is granted.
  - Granted req_ready bit =1 in the same cycle.
  - On that edge: capture a/b/ci/sel into operand regs, set grant_id, go to EXEC.
  - No valid: stay in IDLE; req_ready=0.
- EXEC (1 cycle):
  - alu_* outputs come from operand regs; they are registered and stay stable from EXEC through RESP.
  - On the edge: capture alu_result into rsp_result and {alu_n,alu_z,alu_c,alu_v} into rsp_flags, go to RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_result/rsp_flags held stable while rsp_ready[grant_id]=0.
  - On rsp_ready[grant_id]=1: go to IDLE; pointer <= ~grant_id.
  - rsp_ready of the non-granted requester is ignored.
- Latency: acceptance edge T, rsp_valid high in cycle T+2. Minimum 3 cycles per operation (no back-to-back acceptance in RESP).
- req_ready=0 in EXEC and RESP regardless of req_valid.
- Requester protocol: hold valid and operands until req_ready. If valid drops before grant, there is no effect and nothing is captured.
- Starvation-free: with both requesters continuously valid, grants alternate 0,1,0,1.
- Single requester: served repeatedly; pointer flips anyway, which is harmless.
- Reset mid-operation: in-flight operation discarded, no response issued, all outputs return to reset values immediately.
- No arithmetic in this block; flags are passed through unmodified.

Test Plan:
- Bench uses a stub ALU (result=a+b+ci, C=carry out, Z=(result==0), N=result[3], V=signed overflow).
- Reset, then req_valid=2'b01, a0=3, b0=1, ci=0, sel0=4'b0000 -> req_ready=01 same cycle; in EXEC alu_a=3, alu_b=1, alu_sel=0; rsp_valid=01 two cycles later, rsp_result=4, rsp_flags=4'b0000.
- Both valid at once after reset (a0=7,b0=1; a1=15,b1=1) -> requester 0 first: result 8, flags {N=1,Z=0,C=0,V=1}. Then requester 1: result 0, flags {N=0,Z=1,C=1,V=0}. Grants alternate on repeated simultaneous requests.
- Response backpressure: rsp_ready[0]=0 for 5 cycles -> rsp_valid, rsp_result, rsp_flags stable. req_valid[1] held high meanwhile -> req_ready[1]=0 throughout; requester 1 granted in the first IDLE cycle after rsp_ready[0]=1.
- Wrong-channel ready: rsp_ready=2'b10 while grant_id=0 -> stays in RESP, rsp_valid=01 held.
- rst_n pulsed low during EXEC -> all outputs 0 asynchronously. After release, no stale rsp_valid; a new request completes normally with pointer=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Operands and results are registered; the response is held until the owner accepts it.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_ci,
  input  logic [SEL_W-1:0] req_sel0,
  input  logic [SEL_W-1:0] req_sel1,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ci,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic             gid;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_ci;
  logic [SEL_W-1:0] op_sel;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flg_q;
  logic             win;
  logic             grant_any;
  logic             rsp_done;

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    win       = ptr;
    grant_any = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          grant_any = 1'b1;
          // contention resolved by the pointer, otherwise the lone requester wins
          win       = (req_valid == 2'b11) ? ptr : req_valid[1];
          req_ready = win ? 2'b10 : 2'b01;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = gid ? 2'b10 : 2'b01;
        if (rsp_ready[gid]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      gid    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_ci  <= 1'b0;
      op_sel <= '0;
      res_q  <= '0;
      flg_q  <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        gid    <= win;
        op_a   <= win ? req_a1 : req_a0;
        op_b   <= win ? req_b1 : req_b0;
        op_ci  <= req_ci[win];
        op_sel <= win ? req_sel1 : req_sel0;
      end
      if (state == EXEC) begin
        res_q <= alu_result;
        flg_q <= {alu_n, alu_z, alu_c, alu_v};
      end
      if (rsp_done) ptr <= ~gid;
    end
  end

  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign alu_ci     = op_ci;
  assign alu_sel    = op_sel;
  assign rsp_result = res_q;
  assign rsp_flags  = flg_q;
  assign busy       = (state != IDLE);
  assign grant_id   = gid;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a stub adder ALU
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req_a0 = 0, req_a1 = 0, req_b0 = 0, req_b1 = 0;
  logic [1:0] req_ci = 2'b00;
  logic [3:0] req_sel0 = 0, req_sel1 = 0;
  logic [1:0] req_ready, rsp_valid;
  logic [1:0] rsp_ready = 2'b11;
  logic [3:0] rsp_result, rsp_flags, alu_a, alu_b, alu_sel, alu_result;
  logic       alu_ci, alu_n, alu_z, alu_c, alu_v, busy, grant_id;
  logic [4:0] sum5;

  alu_arbiter #(.WIDTH(4), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_ci(req_ci), .req_sel0(req_sel0), .req_sel1(req_sel1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // stub ALU
  assign sum5       = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_ci};
  assign alu_result = sum5[3:0];
  assign alu_c      = sum5[4];
  assign alu_z      = (sum5[3:0] == 4'd0);
  assign alu_n      = sum5[3];
  assign alu_v      = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);

  typedef struct packed {
    logic       id;
    logic [3:0] a, b;
    logic       ci;
    logic [3:0] sel;
    logic [3:0] res, flg;
  } exp_t;

  exp_t       q[$];
  int         total = 0, bad = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         busy_m = 0;
  bit         prefer_m = 0;
  logic [1:0] acc_flag = 2'b00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: 4-bit add computed with integer arithmetic, flags {N,Z,C,V}
  function automatic logic [7:0] ref_alu(input int a, input int b, input int ci);
    int s, r, sa, sb, sv;
    logic n, z, c, v;
    s  = a + b + ci;
    r  = s % 16;
    c  = (s > 15);
    z  = (r == 0);
    n  = (r >= 8);
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    sv = sa + sb + ci;
    v  = (sv > 7) || (sv < -8);
    return {r[3:0], n, z, c, v};
  endfunction

  always @(posedge clk) cyc++;

  // monitor: predicts grants, pushes expectations, checks responses
  always @(negedge clk) begin
    if (rst_n) begin
      logic [1:0] exp_rr;
      exp_t       e;
      logic [7:0] r;
      exp_rr = 2'b00;
      if (!busy_m) begin
        if (req_valid == 2'b11) exp_rr = prefer_m ? 2'b10 : 2'b01;
        else                    exp_rr = req_valid;
      end
      chk("req_ready", req_ready, exp_rr);
      if (exp_rr != 2'b00 && req_ready == exp_rr) begin
        e.id  = exp_rr[1];
        e.a   = e.id ? req_a1 : req_a0;
        e.b   = e.id ? req_b1 : req_b0;
        e.ci  = req_ci[e.id];
        e.sel = e.id ? req_sel1 : req_sel0;
        r     = ref_alu(e.a, e.b, e.ci);
        e.res = r[7:4];
        e.flg = r[3:0];
        q.push_back(e);
        busy_m = 1;
        acc_cyc = cyc;
        acc_flag[e.id] = 1'b1;
      end else if (busy_m && q.size() > 0 && cyc == acc_cyc + 1) begin
        chk("exec_alu_a", alu_a, q[0].a);
        chk("exec_alu_b", alu_b, q[0].b);
        chk("exec_alu_ci", alu_ci, q[0].ci);
        chk("exec_alu_sel", alu_sel, q[0].sel);
        chk("exec_busy", busy, 1);
        chk("exec_rsp_valid", rsp_valid, 0);
      end
      if (busy_m && cyc == acc_cyc + 2) chk("latency_rsp_valid", rsp_valid != 0, 1);
      if (rsp_valid != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp_valid", rsp_valid, 0);
        end else begin
          chk("rsp_valid", rsp_valid, q[0].id ? 2 : 1);
          chk("rsp_result", rsp_result, q[0].res);
          chk("rsp_flags", rsp_flags, q[0].flg);
          chk("grant_id", grant_id, q[0].id);
          chk("resp_busy", busy, 1);
          if (rsp_ready[q[0].id]) begin
            prefer_m = ~q[0].id;
            void'(q.pop_front());
            busy_m = 0;
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input int a, input int b, input int ci, input int sel);
    if (i == 0) begin
      req_a0 = a[3:0]; req_b0 = b[3:0]; req_sel0 = sel[3:0];
    end else begin
      req_a1 = a[3:0]; req_b1 = b[3:0]; req_sel1 = sel[3:0];
    end
    req_ci[i]    = ci[0];
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc_flag[i]) begin
        req_valid[i] = 1'b0;
        acc_flag[i]  = 1'b0;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while ((req_valid != 0 || busy_m || q.size() != 0) && n < 60);
    chk({name, "_drain_timeout"}, n >= 60, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_flags"}, rsp_flags, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_ci"}, alu_ci, 0);
    chk({tag, "_alu_sel"}, alu_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  initial begin
    int n;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // single requester 0: 3+1
    set_req(0, 3, 1, 0, 0);
    drain("single");

    // simultaneous requests, repeated to observe alternation
    for (int k = 0; k < 3; k++) begin
      set_req(0, 7, 1, 0, 0);
      set_req(1, 15, 1, 0, 1);
      drain("both");
    end

    // response backpressure with requester 1 waiting
    rsp_ready = 2'b00;
    set_req(0, 5, 6, 1, 2);
    step();
    set_req(1, 9, 9, 0, 3);
    repeat (6) step();
    rsp_ready = 2'b10;
    repeat (3) step();
    chk("wrong_channel_rsp_valid", rsp_valid, 1);
    chk("wrong_channel_req_ready1", req_ready[1], 0);
    rsp_ready = 2'b11;
    drain("backpressure");

    // reset during EXEC
    set_req(1, 4, 4, 0, 0);
    n = 0;
    while (!acc_flag[1] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_accept_timeout", acc_flag[1], 1);
    step();
    chk("rst_in_exec_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    q.delete();
    busy_m = 0; prefer_m = 0; acc_flag = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_reset_no_rsp", rsp_valid, 0);
    set_req(0, 2, 2, 1, 0);
    set_req(1, 8, 8, 0, 0);
    drain("post_reset");

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 15));
      rsp_ready = 2'($urandom_range(0, 3));
    end
    rsp_ready = 2'b11;
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
